// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared widths and state encoding for the 8-way round-robin arbiter.
//   N_REQ       number of requesters
//   IDX_W       width of a requester index
//   arb_state_t arbiter state encoding
package rr_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational rotating-priority picker.
//   reqIn   [7:0] request vector
//   ptr     [2:0] index with highest priority this round
//   pickIdx [2:0] first set request at or above ptr, wrapping 7->0
//   found         at least one request is set
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] reqIn,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pickIdx,
  output logic             found
);

  logic [IDX_W-1:0] w_cand;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    pickIdx = ptr;
    found   = 1'b0;
    w_cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = ptr + IDX_W'(k);
      if (reqIn[w_cand]) begin
        pickIdx = w_cand;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter with registered grant index.
// A grant is held until the owner signals done or drops its request.
// Optional forced release after TIMEOUT cycles when RR_ARB_TIMEOUT_EN is defined.
//   clk           clock
//   rst           asynchronous active-high reset
//   reqIn   [7:0] level-sensitive request vector
//   doneIn        current owner finished (ignored while idle)
//   grantIdx[2:0] index of current or last owner
//   grantValid    grant active
//   timeoutPulse  one-cycle pulse on forced release (0 when feature absent)
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] reqIn,
  input  logic             doneIn,
  output logic [IDX_W-1:0] grantIdx,
  output logic             grantValid,
  output logic             timeoutPulse
);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic [IDX_W-1:0] w_pick;
  logic             w_found;
  logic             w_release;

  rr_pick8 u_pick (
    .reqIn   (reqIn),
    .ptr     (r_ptr),
    .pickIdx (w_pick),
    .found   (w_found)
  );

  // Done and a dropped owner request in the same cycle are one release.
  assign w_release = doneIn | ~reqIn[r_idx];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tpulse;
  logic             w_expire;

  assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));
`endif

  // Arbiter state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_tpulse <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      r_tpulse <= 1'b0;
`endif
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_idx   <= w_pick;
            r_valid <= 1'b1;
            r_state <= ARB_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        ARB_GRANT: begin
          if (w_release) begin
            r_valid <= 1'b0;
            r_ptr   <= r_idx + IDX_W'(1);
            r_state <= ARB_IDLE;
          end
`ifdef RR_ARB_TIMEOUT_EN
          // A normal release in the expiry cycle wins, so no pulse then.
          else if (w_expire) begin
            r_valid  <= 1'b0;
            r_ptr    <= r_idx + IDX_W'(1);
            r_state  <= ARB_IDLE;
            r_tpulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign grantIdx   = r_idx;
  assign grantValid = r_valid;
`ifdef RR_ARB_TIMEOUT_EN
  assign timeoutPulse = r_tpulse;
`else
  assign timeoutPulse = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: self-checking bench for rr_arbiter8 using an expected-grant queue.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reqIn;
  logic       doneIn;
  logic [2:0] grantIdx;
  logic       grantValid;
  logic       timeoutPulse;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [2:0]  exp_q[$];

  rr_arbiter8 #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .reqIn        (reqIn),
    .doneIn       (doneIn),
    .grantIdx     (grantIdx),
    .grantValid   (grantValid),
    .timeoutPulse (timeoutPulse)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst    = 1'b1;
    reqIn  = 8'h00;
    doneIn = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    rst    = 1'b1;
    reqIn  = 8'hFF;
    doneIn = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_checks++;
    if (grantValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", grantValid);
    else n_pass++;
    n_checks++;
    if (grantIdx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", grantIdx);
    else n_pass++;
    n_checks++;
    if (timeoutPulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", timeoutPulse);
    else n_pass++;
    rst = 1'b0;
    exp_q.push_back(3'd0);
    @(negedge clk);
    n_checks++;
    if (grantValid !== 1'b1) $display("FAIL first_grant_valid: got %b want 1", grantValid);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (grantIdx !== e) $display("FAIL first_grant_idx: got %0d want %0d", grantIdx, e);
    else n_pass++;
    doneIn = 1'b1;
    @(negedge clk);
    doneIn = 1'b0;
    reqIn  = 8'h00;
  endtask

  task automatic test_rotation();
    logic [2:0] e;
    logic [2:0] owner;
    bit prev, first;
    int gc, idle;
    do_reset();
    reqIn = 8'hFF;
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    exp_q.push_back(3'd0);
    prev = 0; first = 1; gc = 0; idle = 0; owner = '0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      if (grantValid && !prev) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rot_order: extra grant to %0d", grantIdx);
        else begin
          e = exp_q.pop_front();
          if (grantIdx !== e) $display("FAIL rot_order: got %0d want %0d", grantIdx, e);
          else n_pass++;
        end
        if (!first) begin
          n_checks++;
          if (idle != 1) $display("FAIL rot_gap: got %0d idle cycles want 1", idle);
          else n_pass++;
        end
        first = 0;
        gc    = 0;
        owner = grantIdx;
      end
      n_checks++;
      if (timeoutPulse !== 1'b0) $display("FAIL rot_pulse: got %b want 0", timeoutPulse);
      else n_pass++;
      if (grantValid) begin
        n_checks++;
        if (grantIdx !== owner) $display("FAIL rot_hold: got %0d want %0d", grantIdx, owner);
        else n_pass++;
        gc++;
        doneIn = (gc == 3);
        idle   = 0;
      end else begin
        doneIn = 1'b0;
        idle++;
      end
      prev = grantValid;
      if (exp_q.size() == 0 && !grantValid && !first) break;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rot_timeout: %0d grants missing want 0", exp_q.size());
    else n_pass++;
    reqIn  = 8'h00;
    doneIn = 1'b0;
  endtask

  task automatic test_wrap();
    logic [2:0] e;
    bit prev;
    int grants;
    do_reset();
    reqIn = 8'h40;
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd6);
    prev = 0; grants = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (grantValid && !prev) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL wrap_order: extra grant to %0d", grantIdx);
        else begin
          e = exp_q.pop_front();
          if (grantIdx !== e) $display("FAIL wrap_order: got %0d want %0d", grantIdx, e);
          else n_pass++;
        end
        grants++;
        doneIn = 1'b1;
        reqIn  = 8'h41;
      end else begin
        doneIn = 1'b0;
      end
      prev = grantValid;
      if (exp_q.size() == 0 && !grantValid && grants >= 3) break;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL wrap_timeout: %0d grants missing want 0", exp_q.size());
    else n_pass++;
    reqIn  = 8'h00;
    doneIn = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [2:0] e;
    int bad;
    do_reset();
    reqIn = 8'h08;
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (grantValid !== 1'b1 || grantIdx !== e)
      $display("FAIL simul_first: got valid=%b idx=%0d want valid=1 idx=%0d", grantValid, grantIdx, e);
    else n_pass++;
    reqIn  = 8'h10;
    doneIn = 1'b1;
    @(negedge clk);
    doneIn = 1'b0;
    n_checks++;
    if (grantValid !== 1'b0) $display("FAIL simul_release: got valid=%b want 0", grantValid);
    else n_pass++;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (grantValid !== 1'b1 || grantIdx !== e)
      $display("FAIL simul_next: got valid=%b idx=%0d want valid=1 idx=%0d", grantValid, grantIdx, e);
    else n_pass++;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (grantValid !== 1'b1 || grantIdx !== 3'd4) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL simul_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
    reqIn = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_grant();
    logic [2:0] e;
    do_reset();
    reqIn = 8'h20;
    exp_q.push_back(3'd5);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (grantValid !== 1'b1 || grantIdx !== e)
      $display("FAIL midrst_grant: got valid=%b idx=%0d want valid=1 idx=%0d", grantValid, grantIdx, e);
    else n_pass++;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (grantValid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", grantValid);
    else n_pass++;
    n_checks++;
    if (grantIdx !== 3'd0) $display("FAIL midrst_idx: got %0d want 0", grantIdx);
    else n_pass++;
    n_checks++;
    if (timeoutPulse !== 1'b0) $display("FAIL midrst_pulse: got %b want 0", timeoutPulse);
    else n_pass++;
    @(negedge clk);
    reqIn = 8'h00;
    rst   = 1'b0;
  endtask

  task automatic test_lone_requester();
    logic [2:0] e;
    bit prev, first;
    int idle, grants, bad;
    do_reset();
    reqIn = 8'h04;
    repeat (3) exp_q.push_back(3'd2);
    prev = 0; first = 1; idle = 0; grants = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (grantValid && !prev) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL lone_order: extra grant to %0d", grantIdx);
        else begin
          e = exp_q.pop_front();
          if (grantIdx !== e) $display("FAIL lone_order: got %0d want %0d", grantIdx, e);
          else n_pass++;
        end
        if (!first) begin
          n_checks++;
          if (idle != 1) $display("FAIL lone_gap: got %0d idle cycles want 1", idle);
          else n_pass++;
        end
        first = 0;
        grants++;
      end
      if (grantValid) begin
        doneIn = 1'b1;
        idle   = 0;
      end else begin
        doneIn = 1'b0;
        idle++;
      end
      prev = grantValid;
      if (exp_q.size() == 0 && !grantValid && grants >= 3) break;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL lone_timeout: %0d grants missing want 0", exp_q.size());
    else n_pass++;
    // Idle with doneIn high: nothing should move and grantIdx keeps the last owner.
    reqIn  = 8'h00;
    doneIn = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (grantValid !== 1'b0 || grantIdx !== 3'd2) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL idle_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
    doneIn = 1'b0;
    reqIn  = 8'h80;
    exp_q.push_back(3'd7);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (grantValid !== 1'b1 || grantIdx !== e)
      $display("FAIL idle_then_grant: got valid=%b idx=%0d want valid=1 idx=%0d", grantValid, grantIdx, e);
    else n_pass++;
    reqIn = 8'h00;
    @(negedge clk);
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [2:0] e;
    int len;
    bit seen;
    do_reset();
    reqIn = 8'h04;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd2);
    seen = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (grantValid) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) $display("FAIL to_first_grant: got no grant want grant to 2");
    else begin
      e = exp_q.pop_front();
      if (grantIdx !== e) $display("FAIL to_first_grant: got %0d want %0d", grantIdx, e);
      else n_pass++;
    end
    len = 0;
    for (int cyc = 0; cyc < 20 && grantValid; cyc++) begin
      len++;
      @(negedge clk);
    end
    n_checks++;
    if (len != 4) $display("FAIL to_length: got %0d cycles want 4", len);
    else n_pass++;
    n_checks++;
    if (timeoutPulse !== 1'b1 || grantValid !== 1'b0)
      $display("FAIL to_pulse: got pulse=%b valid=%b want pulse=1 valid=0", timeoutPulse, grantValid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (timeoutPulse !== 1'b0) $display("FAIL to_pulse_width: got %b want 0", timeoutPulse);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (grantValid !== 1'b1 || grantIdx !== e)
      $display("FAIL to_regrant: got valid=%b idx=%0d want valid=1 idx=%0d", grantValid, grantIdx, e);
    else n_pass++;
    reqIn = 8'h00;
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    logic [2:0] e;
    int bad;
    do_reset();
    reqIn = 8'h04;
    exp_q.push_back(3'd2);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (grantValid !== 1'b1 || grantIdx !== e)
      $display("FAIL hold_grant: got valid=%b idx=%0d want valid=1 idx=%0d", grantValid, grantIdx, e);
    else n_pass++;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (grantValid !== 1'b1 || grantIdx !== 3'd2 || timeoutPulse !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL hold_forever: got %0d bad cycles want 0", bad);
    else n_pass++;
    reqIn = 8'h00;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst    = 1'b1;
    reqIn  = 8'h00;
    doneIn = 1'b0;
    test_reset();
    test_rotation();
    test_wrap();
    test_simultaneous();
    test_reset_mid_grant();
    test_lone_requester();
`ifdef RR_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
